// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS datapath.
// Memory access stage state encoding, reset instruction and alignment mask.
package mips_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Bus wait counter: counts BUSY cycles without ready and flags the last
// permitted wait cycle so the access can be aborted.
module bus_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign hit = (cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: single-beat req/ready transaction on the unified
// instruction/data bus, holding IR and MDR and stalling the control FSM.
module mem_access_unit
   import mips_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] wdata,
   input  logic              IorD,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              ir_write,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] mdr,
   output logic              stall,
   output logic              addr_err,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ready,
   input  logic [DATA_W-1:0] bus_rdata
);

   mem_state_t        state, state_nxt;
   logic [DATA_W-1:0] addr;
   logic              start, aligned, accept, misalign;
   logic              done, abort, hit;

   logic [DATA_W-1:0] addr_q, wdata_q, ir_q, mdr_q;
   logic              we_q, irw_q, addr_err_q, bus_err_q;

   always_comb begin
      addr      = IorD ? alu_out : pc;
      start     = (state == IDLE) && (mem_read || mem_write);
      aligned   = ((addr[1:0] & ALIGN_MASK) == 2'b00);
      accept    = start && aligned;
      misalign  = start && !aligned;
      done      = (state == BUSY) && bus_ready;
      abort     = (state == BUSY) && !bus_ready && hit;
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (done || abort) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Released in the done/abort cycle so control advances in lockstep.
      stall = accept || ((state == BUSY) && !bus_ready && !hit);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   bus_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk  (clk),
      .rstn (rstn),
      .clr  (accept),
      .en   ((state == BUSY) && !bus_ready),
      .hit  (hit)
   );

   // Request latches hold the bus fields stable for the whole transaction.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         irw_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= {addr[DATA_W-1:2], 2'b00};
         wdata_q <= wdata;
         we_q    <= mem_write;
         irw_q   <= ir_write && !mem_write;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ir_q  <= DATA_W'(NOP_INSTR);
         mdr_q <= '0;
      end else if (done && !we_q) begin
         mdr_q <= bus_rdata;
         if (irw_q) ir_q <= bus_rdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_err_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         addr_err_q <= misalign;
         bus_err_q  <= abort;
      end
   end

   assign bus_req   = (state == BUSY);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign instr     = ir_q;
   assign mdr       = mdr_q;
   assign addr_err  = addr_err_q;
   assign bus_err   = bus_err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage of the multi-cycle MIPS CPU. It sits directly downstream of `control_unit`. It consumes `IorD`, `ir_write` and `mem_write`, plus a new `mem_read` strobe driven by the FSM in FETCH and MEM_READ. It selects the address from PC or ALU result and runs a single-beat req/ready transaction on the unified instruction/data memory bus. It holds the instruction register (IR) and memory data register (MDR), and returns `stall` so the control FSM holds its state while memory is busy.

## Interface
Parameters:
- `DATA_W`, 32, data/address width.
- `TIMEOUT`, 255, max bus wait cycles before abort (≥1).

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `pc` in DATA_W: fetch address.
- `alu_out` in DATA_W: data address.
- `wdata` in DATA_W: store data (rt).
- `IorD` in 1: 0 = use `pc`, 1 = use `alu_out`.
- `mem_read` in 1: request read.
- `mem_write` in 1: request write.
- `ir_write` in 1: read result goes to IR (and MDR).
- `instr` out DATA_W: IR contents.
- `mdr` out DATA_W: MDR contents.
- `stall` out 1: control FSM must hold state.
- `addr_err` out 1: one-cycle pulse, misaligned request rejected.
- `bus_err` out 1: one-cycle pulse, bus timeout.
- `bus_req` out 1: transaction valid.
- `bus_we` out 1: write transaction.
- `bus_addr` out DATA_W: word-aligned address.
- `bus_wdata` out DATA_W: write data.
- `bus_ready` in 1: memory accepts/completes this cycle.
- `bus_rdata` in DATA_W: read data, valid when `bus_req & bus_ready & ~bus_we`.

## Operation
- States: IDLE, BUSY.
- start = IDLE & (`mem_read` | `mem_write`).
- Address mux: addr = `IorD ? alu_out : pc`.
- IDLE, start, addr[1:0]==0:
  - latch addr, `wdata`, we=`mem_write`, irw=`ir_write & ~mem_write`.
  - go to BUSY.
- IDLE, start, addr[1:0]!=0:
  - no transaction; stay IDLE.
  - `addr_err`=1 next cycle; IR/MDR unchanged.
- Read and write together: write wins; read ignored.
- BUSY:
  - `bus_req`=1; `bus_addr`/`bus_we`/`bus_wdata` come from latches and are stable until done.
  - Done when `bus_ready`=1 → IDLE.
  - On a done read: MDR ← `bus_rdata`; if irw, IR ← `bus_rdata` as well.
  - Writes update neither IR nor MDR.
- Timeout: wait counter, width $clog2(TIMEOUT+1), cleared on entry to BUSY, +1 each BUSY cycle without ready.
  - BUSY with counter == TIMEOUT-1 and no ready → abort to IDLE.
  - Next cycle: `bus_err`=1; IR/MDR unchanged.
- stall = start & aligned | BUSY & ~`bus_ready` & ~timeout_hit.
- In the done/abort cycle `stall`=0, so control advances; request inputs in that cycle are ignored (state is BUSY).
- Reset (any time, including mid-transaction): state IDLE, counter 0, all outputs 0, IR=0 (NOP), MDR=0. A pending transaction is dropped and `bus_req` deasserts asynchronously.

## Timing
- Request seen in cycle T. `bus_req` rises at T+1.
- Ready at T+k (k≥1): IR/MDR visible at T+k+1.
- Minimum access = 2 cycles (stall high in T only).
- `stall` is combinational from the inputs; all other outputs are registered. `bus_req` is driven from state only.
- `addr_err` and `bus_err` are high exactly one cycle.
- Timeout: the last BUSY cycle is T+TIMEOUT and `bus_err` is at T+TIMEOUT+1.
- Back-to-back: the next request can start at T+k+1.

## Structure
- Shared `mips_pkg` holds:
  - `mem_state_t` enum {IDLE, BUSY}, `logic [0:0]`.
  - `NOP_INSTR` = 32'h0.
  - `ALIGN_MASK` = 2'b11.
- Sub-module `bus_timeout_ctr`:
  - parameter TIMEOUT.
  - inputs clk, rstn, clr, en.
  - output hit.
- Remaining logic (about 150–200 lines): FSM, latches, IR/MDR.

## Test plan
- Fetch: pc=0x0000_0010, IorD=0, mem_read=1, ir_write=1, ready at T+1, rdata=0x2008_0005 → bus_addr=0x10 at T+1; instr=mdr=0x2008_0005 at T+2; stall high only at T.
- Load with 3 wait states: alu_out=0x100, ready at T+4, rdata=0xDEAD_BEEF → stall T..T+3; mdr=0xDEAD_BEEF at T+5; instr unchanged.
- Store: alu_out=0x204, wdata=0x1234_5678, mem_write=1, mem_read=1 → bus_we=1, bus_wdata=0x1234_5678, single transaction; IR/MDR unchanged.
- Misaligned: alu_out=0x102, mem_read=1 → bus_req stays 0; addr_err=1 at T+1 only; stall=0.
- Timeout: TIMEOUT=4, ready held 0 → bus_req high T+1..T+4; bus_err=1 at T+5; stall low at T+4; IR/MDR unchanged.
- Reset mid-BUSY: rstn low at T+2 of a waiting read → bus_req=0 immediately; instr=0, mdr=0; the next fetch after release completes normally.
